fp_add_pipe: RTL and testbench



---
 rtl/fp_add_pkg.sv | 27 ++
 rtl/fp_add_pipe_if.sv | 44 ++++
 rtl/fp_lzc.sv | 37 +++
 rtl/fp_add_pipe.sv | 179 +++++++++++++++++
 tb/tb_fp_add_pipe.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pkg
//  Description : Shared constants and helpers for the pipelined sign-magnitude
//                floating-point adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_add_pkg;

    // Operation select encoding
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Ceiling log2, used to size the leading-zero count
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pipe_if
//  Description : Operand-in / result-out valid-ready stream bundle for the
//                floating-point adder. The master issues operands and
//                consumes results; the slave is the adder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_add_pipe_if #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
);
    // Operand side
    logic              in_valid;
    logic              in_ready;
    logic              op;
    logic              sign1;
    logic              sign2;
    logic [EXP_W-1:0]  exp1;
    logic [EXP_W-1:0]  exp2;
    logic [FRAC_W-1:0] frac1;
    logic [FRAC_W-1:0] frac2;

    // Result side
    logic              out_valid;
    logic              out_ready;
    logic              sign_out;
    logic [EXP_W-1:0]  exp_out;
    logic [FRAC_W-1:0] frac_out;
    logic              ovf;
    logic              unf;

    modport master (
        output in_valid, op, sign1, sign2, exp1, exp2, frac1, frac2, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, frac_out, ovf, unf
    );

    modport slave (
        input  in_valid, op, sign1, sign2, exp1, exp2, frac1, frac2, out_ready,
        output in_ready, out_valid, sign_out, exp_out, frac_out, ovf, unf
    );

endinterface
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Parametrised combinational leading-zero counter. Count is the
//                number of zero bits above the most significant one; zero is
//                set when no bit is set (count is then 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc
    import fp_add_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = (clog2(W) < 1) ? 1 : clog2(W)
) (
    input  wire logic [W-1:0]  i_data,
    output logic      [CW-1:0] o_count,
    output logic               o_zero
);

    logic w_found;

    // Priority scan from the MSB; the first set bit fixes the count
    always_comb begin
        o_count = '0;
        w_found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!w_found && i_data[i]) begin
                o_count = CW'(W - 1 - i);
                w_found = 1'b1;
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule
`default_nettype wire

// File: rtl/fp_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pipe
//  Description : Three-stage pipelined sign-magnitude floating-point adder /
//                subtractor. Value = (-1)^s * 0.frac * 2^exp, unbiased
//                exponent, explicit fraction MSB. Stage 1 swaps and aligns,
//                stage 2 adds or subtracts magnitudes, stage 3 normalises,
//                saturates on overflow and flushes underflow to zero.
//                A single advance enable stalls the whole pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fp_add_pipe_if.slave  bus
);

    localparam int LZ_W = (clog2(FRAC_W) < 1) ? 1 : clog2(FRAC_W);

    // Per-stage payloads, each carrying its own valid bit
    typedef struct packed {
        logic              valid;
        logic              sign;     // sign of the big operand
        logic              eff_sub;  // effective signs differ
        logic [EXP_W-1:0]  expb;
        logic [FRAC_W-1:0] fracb;
        logic [FRAC_W-1:0] fraca;    // small fraction after alignment
    } s1_t;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [EXP_W-1:0]  expb;
        logic [FRAC_W:0]   sum;      // includes carry bit
    } s2_t;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              ovf;
        logic              unf;
    } s3_t;

    s1_t r_s1;
    s2_t r_s2;
    s3_t r_s3;
    s1_t w_s1_d;
    s2_t w_s2_d;
    s3_t w_s3_d;

    logic              w_en;
    logic              w_sign2_eff;
    logic              w_op1_big;
    logic              w_signb;
    logic              w_signs;
    logic [EXP_W-1:0]  w_expb;
    logic [EXP_W-1:0]  w_exps;
    logic [FRAC_W-1:0] w_fracb;
    logic [FRAC_W-1:0] w_fracs;
    logic [EXP_W-1:0]  w_diff;
    logic [LZ_W-1:0]   w_lz;
    logic              w_lz_zero;

    // Whole pipe advances whenever the output slot is free or being drained;
    // empty earlier stages do not let new operands in while the output stalls
    assign w_en         = !r_s3.valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // Stage 1: pick the larger-magnitude operand (operand 2 on a tie) and
    // align the smaller fraction, truncating shifted-out bits
    always_comb begin
        w_sign2_eff = bus.sign2 ^ (bus.op == OP_SUB);
        w_op1_big   = {bus.exp1, bus.frac1} > {bus.exp2, bus.frac2};
        if (w_op1_big) begin
            w_signb = bus.sign1;
            w_signs = w_sign2_eff;
            w_expb  = bus.exp1;
            w_exps  = bus.exp2;
            w_fracb = bus.frac1;
            w_fracs = bus.frac2;
        end else begin
            w_signb = w_sign2_eff;
            w_signs = bus.sign1;
            w_expb  = bus.exp2;
            w_exps  = bus.exp1;
            w_fracb = bus.frac2;
            w_fracs = bus.frac1;
        end
        w_diff         = w_expb - w_exps;
        w_s1_d         = '0;
        w_s1_d.valid   = bus.in_valid && w_en;
        w_s1_d.sign    = w_signb;
        w_s1_d.eff_sub = w_signb ^ w_signs;
        w_s1_d.expb    = w_expb;
        w_s1_d.fracb   = w_fracb;
        if (32'(w_diff) >= 32'(FRAC_W)) begin
            w_s1_d.fraca = '0;
        end else begin
            w_s1_d.fraca = w_fracs >> w_diff;
        end
    end

    // Stage 2: magnitude add or subtract; big >= small so no borrow out
    always_comb begin
        w_s2_d       = '0;
        w_s2_d.valid = r_s1.valid;
        w_s2_d.sign  = r_s1.sign;
        w_s2_d.expb  = r_s1.expb;
        if (r_s1.eff_sub) begin
            w_s2_d.sum = {1'b0, r_s1.fracb} - {1'b0, r_s1.fraca};
        end else begin
            w_s2_d.sum = {1'b0, r_s1.fracb} + {1'b0, r_s1.fraca};
        end
    end

    fp_lzc #(
        .W (FRAC_W)
    ) u_lzc (
        .i_data  (r_s2.sum[FRAC_W-1:0]),
        .o_count (w_lz),
        .o_zero  (w_lz_zero)
    );

    // Stage 3: normalise; carry, exact zero, underflow, then left-shift
    always_comb begin
        w_s3_d       = '0;
        w_s3_d.valid = r_s2.valid;
        if (r_s2.sum[FRAC_W]) begin
            w_s3_d.sign = r_s2.sign;
            if (&r_s2.expb) begin
                w_s3_d.exp  = '1;
                w_s3_d.frac = '1;
                w_s3_d.ovf  = 1'b1;
            end else begin
                w_s3_d.exp  = r_s2.expb + 1'b1;
                w_s3_d.frac = r_s2.sum[FRAC_W:1];
            end
        end else if (w_lz_zero) begin
            // Exact cancellation: positive zero, no flags
            w_s3_d.sign = 1'b0;
        end else if (32'(w_lz) > 32'(r_s2.expb)) begin
            // Normalising would need a negative exponent: flush to zero
            w_s3_d.unf = 1'b1;
        end else begin
            w_s3_d.sign = r_s2.sign;
            w_s3_d.exp  = r_s2.expb - EXP_W'(w_lz);
            w_s3_d.frac = r_s2.sum[FRAC_W-1:0] << w_lz;
        end
    end

    // Pipeline registers: shift together on enable, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else if (w_en) begin
            r_s1 <= w_s1_d;
            r_s2 <= w_s2_d;
            r_s3 <= w_s3_d;
        end
    end

    assign bus.out_valid = r_s3.valid;
    assign bus.sign_out  = r_s3.sign;
    assign bus.exp_out   = r_s3.exp;
    assign bus.frac_out  = r_s3.frac;
    assign bus.ovf       = r_s3.ovf;
    assign bus.unf       = r_s3.unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_pipe
//  Description : Directed table-driven bench for fp_add_pipe (default widths)
//                plus back-pressure and mid-stream reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_pipe;
    import fp_add_pkg::*;

    typedef struct packed {
        logic       op;
        logic       s1;
        logic [3:0] e1;
        logic [7:0] f1;
        logic       s2;
        logic [3:0] e2;
        logic [7:0] f2;
        logic       es;
        logic [3:0] ee;
        logic [7:0] ef;
        logic       eovf;
        logic       eunf;
    } vec_t;

    localparam int NV = 15;

    logic clk;
    logic rst_n;
    vec_t vt [NV];
    int   n_applied;
    int   n_miss;

    fp_add_pipe_if #(.EXP_W(4), .FRAC_W(8)) bus ();

    fp_add_pipe #(
        .EXP_W  (4),
        .FRAC_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required run completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic op, input logic s1, input logic [3:0] e1,
                                input logic [7:0] f1, input logic s2, input logic [3:0] e2,
                                input logic [7:0] f2, input logic es, input logic [3:0] ee,
                                input logic [7:0] ef, input logic eovf, input logic eunf);
        vec_t v;
        v = {op, s1, e1, f1, s2, e2, f2, es, ee, ef, eovf, eunf};
        return v;
    endfunction

    function automatic logic [14:0] exp_res(input vec_t v);
        return {v.es, v.ee, v.ef, v.eovf, v.eunf};
    endfunction

    function automatic logic [14:0] act_res();
        return {bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf, bus.unf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_applied++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld);
        bus.in_valid = vld;
        bus.op       = v.op;
        bus.sign1    = v.s1;
        bus.exp1     = v.e1;
        bus.frac1    = v.f1;
        bus.sign2    = v.s2;
        bus.exp2     = v.e2;
        bus.frac2    = v.f2;
    endtask

    // One isolated operation: accept edge counts as cycle 1, result must be
    // visible after the third rising edge
    task automatic run_vec(input int i, input string tag);
        int lat;
        drive(vt[i], 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s vec%0d latency", tag, i), 32'(lat), 32'd3);
        check($sformatf("%s vec%0d result", tag, i), 32'(act_res()), 32'(exp_res(vt[i])));
    endtask

    initial begin
        int   issued;
        int   received;
        int   stall_cnt;
        int   steps;
        int   extra;
        logic stall_seen;
        logic [14:0] snap;

        n_applied = 0;
        n_miss    = 0;
        //            op      s1 e1 f1     s2 e2 f2     es ee f2res  ovf unf
        vt[0]  = mk(OP_ADD, 0, 3, 8'h80, 0, 3, 8'h80, 0, 4, 8'h80, 0, 0);
        vt[1]  = mk(OP_ADD, 0, 5, 8'hC0, 0, 2, 8'h80, 0, 5, 8'hD0, 0, 0);
        vt[2]  = mk(OP_ADD, 0, 12, 8'h9A, 0, 3, 8'hFF, 0, 12, 8'h9A, 0, 0);
        vt[3]  = mk(OP_SUB, 0, 6, 8'hA5, 0, 6, 8'hA5, 0, 0, 8'h00, 0, 0);
        vt[4]  = mk(OP_SUB, 0, 1, 8'hC0, 0, 1, 8'hA0, 0, 0, 8'h00, 0, 1);
        vt[5]  = mk(OP_ADD, 0, 15, 8'hFF, 0, 15, 8'h80, 0, 15, 8'hFF, 1, 0);
        vt[6]  = mk(OP_ADD, 0, 14, 8'h80, 0, 14, 8'h80, 0, 15, 8'h80, 0, 0);
        vt[7]  = mk(OP_ADD, 1, 4, 8'h80, 0, 3, 8'h80, 1, 3, 8'h80, 0, 0);
        vt[8]  = mk(OP_SUB, 0, 2, 8'h80, 1, 2, 8'h40, 0, 2, 8'hC0, 0, 0);
        vt[9]  = mk(OP_SUB, 0, 2, 8'h80, 0, 2, 8'h60, 0, 0, 8'h80, 0, 0);
        vt[10] = mk(OP_ADD, 0, 1, 8'h40, 1, 3, 8'h80, 1, 2, 8'hE0, 0, 0);
        vt[11] = mk(OP_ADD, 0, 10, 8'h81, 0, 2, 8'hFF, 0, 10, 8'h81, 0, 0);
        vt[12] = mk(OP_ADD, 0, 9, 8'h80, 0, 2, 8'hFF, 0, 9, 8'h81, 0, 0);
        vt[13] = mk(OP_ADD, 1, 15, 8'hFF, 1, 15, 8'hFF, 1, 15, 8'hFF, 1, 0);
        vt[14] = mk(OP_SUB, 1, 7, 8'h90, 1, 7, 8'h90, 0, 0, 8'h00, 0, 0);

        // Reset state
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive(vt[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset outputs", 32'(act_res()), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, one at a time
        for (int i = 0; i < NV; i++) begin
            run_vec(i, "table");
        end
        @(posedge clk); #1;

        // Back-to-back stream with a 4-cycle stall from the first result
        issued     = 0;
        received   = 0;
        stall_cnt  = 0;
        stall_seen = 1'b0;
        steps      = 0;
        snap       = '0;
        while (received < 6 && steps < 60) begin
            if (bus.out_valid && !stall_seen) begin
                stall_seen = 1'b1;
                stall_cnt  = 4;
                snap       = act_res();
            end
            bus.out_ready = (stall_cnt == 0);
            #1;
            if (stall_cnt > 0) begin
                check("stall in_ready", 32'(bus.in_ready), 32'd0);
                check("stall out_valid", 32'(bus.out_valid), 32'd1);
                if (stall_cnt < 4) begin
                    check("stall hold", 32'(act_res()), 32'(snap));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("stream result %0d", received), 32'(act_res()),
                      32'(exp_res(vt[received])));
                received++;
            end
            if (issued < 6) begin
                drive(vt[issued], 1'b1);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                issued++;
            end
            @(posedge clk); #1;
            if (stall_cnt > 0) begin
                stall_cnt--;
            end
            steps++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream stall seen", 32'(stall_seen), 32'd1);
        check("stream received", 32'(received), 32'd6);
        check("stream issued", 32'(issued), 32'd6);
        extra = 0;
        repeat (5) begin
            if (bus.out_valid) extra++;
            @(posedge clk); #1;
        end
        check("stream duplicates", 32'(extra), 32'd0);

        // Mid-stream asynchronous reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            drive(vt[6 + k], 1'b1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(bus.out_valid), 32'd0);
        check("async reset outputs", 32'(act_res()), 32'd0);
        check("async reset in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        check("post-reset stale results", 32'(extra), 32'd0);

        // Pipe still works after reset
        run_vec(1, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
